// File: rtl/whack_pkg.sv
// Shared constants for the whack-a-mole timing blocks.
// Also holds the load-validation rule used by the tick divider.
package whack_pkg;

    localparam int CLK_HZ    = 100_000_000;
    localparam int DIV_1HZ   = 100_000_000;
    localparam int DIV_1KHZ  = 100_000;
    localparam int DEF_CNT_W = 27;

    // A divisor write is refused when it is zero or aims at a channel that does not exist.
    function automatic logic load_rejected(input logic div_is_zero,
                                           input logic [2:0] ch,
                                           input int num_ch);
        return div_is_zero || (int'(ch) >= num_ch);
    endfunction

endpackage

// File: rtl/tick_channel.sv
// One tick channel: a free-running counter producing a one-cycle tick every `div` cycles,
// a square wave toggling on each tick, and a pending divisor applied only at safe points.
module tick_channel
    import whack_pkg::*;
#(
    parameter int               CNT_W   = DEF_CNT_W,
    parameter logic [CNT_W-1:0] DIV_RST = CNT_W'(1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             sync,
    input  logic             load,
    input  logic [CNT_W-1:0] load_div,
    output logic             tick,
    output logic             square
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] r_div;
    logic [CNT_W-1:0] r_pend_div;
    logic             r_pend_v;
    logic             r_tick;
    logic             r_square;

    logic             w_terminal;
    logic [CNT_W-1:0] w_sync_div;

    // '>=' rather than '==' keeps the counter bounded if a smaller divisor lands while disabled.
    always_comb begin
        w_terminal = (r_count >= (r_div - ONE));
        w_sync_div = r_div;
        if (load) begin
            w_sync_div = load_div;
        end else if (r_pend_v) begin
            w_sync_div = r_pend_div;
        end else begin
            w_sync_div = r_div;
        end
    end

    // Counter, divisor, pending reload, tick and square state.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_count    <= '0;
            r_div      <= DIV_RST;
            r_pend_div <= '0;
            r_pend_v   <= 1'b0;
            r_tick     <= 1'b0;
            r_square   <= 1'b0;
        end else if (sync) begin
            r_count  <= '0;
            r_tick   <= 1'b0;
            r_div    <= w_sync_div;
            r_pend_v <= 1'b0;
        end else begin
            if (enable && !w_terminal) begin
                r_count <= r_count + ONE;
                r_tick  <= 1'b0;
            end else if (enable) begin
                r_count  <= '0;
                r_tick   <= 1'b1;
                r_square <= ~r_square;
                if (r_pend_v) begin
                    r_div    <= r_pend_div;
                    r_pend_v <= 1'b0;
                end
            end else begin
                r_tick <= 1'b0;
                if (r_pend_v) begin
                    r_div    <= r_pend_div;
                    r_pend_v <= 1'b0;
                end
            end
            // A load on the same edge as an apply becomes the next pending value.
            if (load) begin
                r_pend_div <= load_div;
                r_pend_v   <= 1'b1;
            end
        end
    end

    assign tick   = r_tick;
    assign square = r_square;

endmodule

// File: rtl/multi_tick_divider.sv
// Multi-channel tick generator: decodes divisor writes, flags rejected writes,
// and fans the shared sync out to NUM_CH independent tick_channel instances.
module multi_tick_divider
    import whack_pkg::*;
#(
    parameter int                      NUM_CH   = 3,
    parameter int                      CNT_W    = DEF_CNT_W,
    parameter logic [NUM_CH*CNT_W-1:0] DIV_INIT = {27'd100_000_000, 27'd100_000, 27'd25_000_000}
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [NUM_CH-1:0] enable,
    input  logic              sync,
    input  logic              load,
    input  logic [2:0]        load_ch,
    input  logic [CNT_W-1:0]  load_div,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] square,
    output logic              load_err
);

    logic              r_load_err;
    logic              w_load_bad;
    logic              w_load_ok;
    logic [NUM_CH-1:0] w_ch_load;

    always_comb begin
        w_load_bad = load && load_rejected(load_div == '0, load_ch, NUM_CH);
        w_load_ok  = load && !w_load_bad;
    end

    // Rejected-write flag, one cycle after the offending load.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_load_err <= 1'b0;
        end else begin
            r_load_err <= w_load_bad;
        end
    end

    assign load_err = r_load_err;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        assign w_ch_load[g] = w_load_ok && (load_ch == 3'(g));

        tick_channel #(
            .CNT_W   (CNT_W),
            .DIV_RST (DIV_INIT[g*CNT_W +: CNT_W])
        ) u_ch (
            .clock    (clock),
            .reset    (reset),
            .enable   (enable[g]),
            .sync     (sync),
            .load     (w_ch_load[g]),
            .load_div (load_div),
            .tick     (tick[g]),
            .square   (square[g])
        );
    end

endmodule

// File: tb/tb_multi_tick_divider.sv
// Self-checking bench for multi_tick_divider: directed scenarios with fixed expectations
// plus randomized traffic compared against a period-level behavioural model.
module tb_multi_tick_divider;

    localparam int NUM_CH = 3;
    localparam int CNT_W  = 8;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic [NUM_CH-1:0] enable = '0;
    logic              sync = 1'b0;
    logic              load = 1'b0;
    logic [2:0]        load_ch = '0;
    logic [CNT_W-1:0]  load_div = '0;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] square;
    logic              load_err;

    int n_vec = 0;
    int n_err = 0;

    // Model state: cycles elapsed in the current period, active/pending divisors.
    int          div_init [NUM_CH] = '{5, 3, 2};
    int          m_el     [NUM_CH];
    int          m_div    [NUM_CH];
    int          m_pd     [NUM_CH];
    bit          m_pv     [NUM_CH];
    logic [2:0]  m_tick;
    logic [2:0]  m_sq;
    logic        m_err;

    multi_tick_divider #(
        .NUM_CH   (NUM_CH),
        .CNT_W    (CNT_W),
        .DIV_INIT ({8'd2, 8'd3, 8'd5})
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .enable   (enable),
        .sync     (sync),
        .load     (load),
        .load_ch  (load_ch),
        .load_div (load_div),
        .tick     (tick),
        .square   (square),
        .load_err (load_err)
    );

    always #5 clock = ~clock;

    task automatic model_apply(input int i);
        if (m_pv[i]) begin
            m_div[i] = m_pd[i];
            m_pv[i]  = 1'b0;
        end
    endtask

    task automatic model_edge();
        bit ok;
        bit bad;
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                m_el[i] = 0; m_div[i] = div_init[i]; m_pv[i] = 1'b0; m_pd[i] = 0;
            end
            m_tick = '0; m_sq = '0; m_err = 1'b0;
        end else begin
            bad   = load && (load_div == 0 || load_ch >= 3'(NUM_CH));
            ok    = load && !bad;
            m_err = bad;
            for (int i = 0; i < NUM_CH; i++) begin
                if (sync) begin
                    m_el[i]   = 0;
                    m_tick[i] = 1'b0;
                    if (ok && int'(load_ch) == i) m_div[i] = int'(load_div);
                    else if (m_pv[i]) m_div[i] = m_pd[i];
                    m_pv[i] = 1'b0;
                end else begin
                    if (enable[i]) begin
                        m_el[i]++;
                        if (m_el[i] >= m_div[i]) begin
                            m_el[i] = 0; m_tick[i] = 1'b1; m_sq[i] = ~m_sq[i];
                            model_apply(i);
                        end else begin
                            m_tick[i] = 1'b0;
                        end
                    end else begin
                        m_tick[i] = 1'b0;
                        model_apply(i);
                    end
                    if (ok && int'(load_ch) == i) begin
                        m_pd[i] = int'(load_div);
                        m_pv[i] = 1'b1;
                    end
                end
            end
        end
    endtask

    // One rising edge (model follows the same inputs), then settle to the falling edge.
    task automatic step();
        @(posedge clock);
        model_edge();
        @(negedge clock);
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = '0; sync = 1'b0; load = 1'b0;
        step();
        step();
        n_vec++;
        if ({load_err, square, tick} !== 7'b0) begin
            n_err++;
            $display("FAIL reset_outputs: got %b expected %b", {load_err, square, tick}, 7'b0);
        end
    endtask

    task automatic test_basic();
        logic [2:0] exp_t;
        logic [2:0] exp_s;
        reset = 1'b0; enable = 3'b111;
        for (int k = 1; k <= 12; k++) begin
            step();
            exp_t = {k % 2 == 0, k % 3 == 0, k % 5 == 0};
            exp_s = {(k / 2) % 2 == 1, (k / 3) % 2 == 1, (k / 5) % 2 == 1};
            n_vec++;
            if ({square, tick} !== {exp_s, exp_t}) begin
                n_err++;
                $display("FAIL basic_edge%0d: got sq=%b tick=%b expected sq=%b tick=%b",
                         k, square, tick, exp_s, exp_t);
            end
        end
    endtask

    task automatic test_reload();
        reset = 1'b1; enable = '0;
        step();
        reset = 1'b0; load = 1'b1; load_ch = 3'd1; load_div = 8'd4;
        step();
        load = 1'b0;
        step();
        enable = 3'b010;
        step();
        load = 1'b1; load_ch = 3'd1; load_div = 8'd2;
        for (int k = 2; k <= 8; k++) begin
            step();
            load = 1'b0;
            n_vec++;
            if (tick[1] !== (k == 4 || k == 6 || k == 8)) begin
                n_err++;
                $display("FAIL reload_edge%0d: got %b expected %b", k, tick[1], (k == 4 || k == 6 || k == 8));
            end
        end
    endtask

    task automatic test_load_err();
        reset = 1'b1; enable = '0;
        step();
        reset = 1'b0; enable = 3'b111;
        load = 1'b1; load_ch = 3'd0; load_div = 8'd0;
        step();
        load = 1'b0;
        n_vec++;
        if (load_err !== 1'b1) begin n_err++; $display("FAIL err_zero_div: got %b expected 1", load_err); end
        step();
        n_vec++;
        if (load_err !== 1'b0) begin n_err++; $display("FAIL err_zero_clear: got %b expected 0", load_err); end
        load = 1'b1; load_ch = 3'd5; load_div = 8'd3;
        step();
        load = 1'b0;
        n_vec++;
        if (load_err !== 1'b1) begin n_err++; $display("FAIL err_bad_ch: got %b expected 1", load_err); end
        step();
        n_vec++;
        if (load_err !== 1'b0) begin n_err++; $display("FAIL err_ch_clear: got %b expected 0", load_err); end
        // Four edges elapsed; divisors must still be {2,3,5}.
        for (int k = 5; k <= 10; k++) begin
            step();
            n_vec++;
            if (tick !== {k % 2 == 0, k % 3 == 0, k % 5 == 0}) begin
                n_err++;
                $display("FAIL err_divs_edge%0d: got %b expected %b", k, tick, {k % 2 == 0, k % 3 == 0, k % 5 == 0});
            end
        end
    endtask

    task automatic test_enable_hold();
        reset = 1'b1; enable = '0;
        step();
        reset = 1'b0; enable = 3'b001;
        step();
        step();
        enable = 3'b000;
        for (int k = 0; k < 10; k++) begin
            step();
            n_vec++;
            if (tick[0] !== 1'b0) begin n_err++; $display("FAIL hold_idle%0d: got %b expected 0", k, tick[0]); end
        end
        enable = 3'b001;
        for (int k = 1; k <= 3; k++) begin
            step();
            n_vec++;
            if (tick[0] !== (k == 3)) begin
                n_err++;
                $display("FAIL hold_resume%0d: got %b expected %b", k, tick[0], (k == 3));
            end
        end
    endtask

    task automatic test_sync(input bit simultaneous);
        logic [2:0] exp_t;
        reset = 1'b1; enable = '0;
        step();
        reset = 1'b0; enable = 3'b111;
        step(); step(); step();
        if (!simultaneous) begin
            load = 1'b1; load_ch = 3'd0; load_div = 8'd7;
        end
        step();
        load = simultaneous; load_ch = 3'd0; load_div = 8'd7; sync = 1'b1;
        step();
        load = 1'b0; sync = 1'b0;
        n_vec++;
        if (tick !== 3'b000) begin n_err++; $display("FAIL sync_edge_%0d: got %b expected 000", simultaneous, tick); end
        for (int k = 1; k <= 8; k++) begin
            step();
            exp_t = {k % 2 == 0, k % 3 == 0, k == 7};
            n_vec++;
            if (tick !== exp_t) begin
                n_err++;
                $display("FAIL sync%0d_after%0d: got %b expected %b", simultaneous, k, tick, exp_t);
            end
        end
    endtask

    task automatic test_reset_mid();
        reset = 1'b0; enable = 3'b111;
        step(); step();
        load = 1'b1; load_ch = 3'd0; load_div = 8'd7;
        step();
        load = 1'b0; reset = 1'b1;
        step();
        n_vec++;
        if ({load_err, square, tick} !== 7'b0) begin
            n_err++;
            $display("FAIL reset_mid_outputs: got %b expected %b", {load_err, square, tick}, 7'b0);
        end
        reset = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            step();
            n_vec++;
            if (tick[0] !== (k % 5 == 0)) begin
                n_err++;
                $display("FAIL reset_mid_edge%0d: got %b expected %b", k, tick[0], (k % 5 == 0));
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 2000; c++) begin
            reset    = ($urandom_range(199) == 0);
            sync     = ($urandom_range(39) == 0);
            load     = ($urandom_range(7) == 0);
            load_ch  = 3'($urandom_range(7));
            load_div = 8'($urandom_range(9));
            if ($urandom_range(9) == 0) enable = 3'($urandom_range(7));
            step();
            n_vec++;
            if ({load_err, square, tick} !== {m_err, m_sq, m_tick}) begin
                n_err++;
                $display("FAIL random_cyc%0d: got err=%b sq=%b tick=%b expected err=%b sq=%b tick=%b",
                         c, load_err, square, tick, m_err, m_sq, m_tick);
            end
        end
        reset = 1'b0; sync = 1'b0; load = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_reload();
        test_load_err();
        test_enable_hold();
        test_sync(1'b0);
        test_sync(1'b1);
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
